instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage directly downstream of the program counter.
- Captures each valid PC and reads the 16-bit instruction from byte-wide program flash as two sequential byte reads.
- Holds the assembled instruction for the decoder under a valid/ready handshake.
- Drives flash_ready back to the program counter, so the PC advances or loads only when the fetch stage is idle.

Parameters:
ADDR_WIDTH, 12, instruction-word address width (PC width); the flash byte address is ADDR_WIDTH+1 bits.
TIMEOUT_CYCLES, 16, maximum cycles one byte read may wait for flash_ack before abort (range 2..255).
NOP_WORD, 16'h0000, instruction word delivered when a fetch times out.

Ports:
clk  in  1  system clock, rising edge.
arst  in  1  asynchronous reset, active-high.
pc_in  in  ADDR_WIDTH  current PC value from the program counter.
pc_valid  in  1  pc_in holds a new address to fetch.
bootstrapping  in  1  PC is in boot region 0x000-0x1FF; captured with pc_in.
flash_ready  out  1  fetch stage idle; the PC may increment or load this cycle.
flush  in  1  discard the current fetch or held instruction (branch/jump).
flash_req  out  1  flash read request.
flash_addr  out  ADDR_WIDTH+1  flash byte address = {pc,0} for the low byte, {pc,1} for the high byte.
flash_rdata  in  8  flash read data, valid when flash_ack=1.
flash_ack  in  1  flash read complete; single-cycle pulse, sampled only while flash_req=1.
instr  out  16  assembled instruction {high byte, low byte}.
instr_pc  out  ADDR_WIDTH  PC of instr.
instr_boot  out  1  instr was fetched with bootstrapping=1.
instr_valid  out  1  instr/instr_pc/instr_boot/fetch_err are valid.
instr_ready  in  1  decoder accepts the instruction.
fetch_err  out  1  instr is NOP_WORD substituted after a timeout.

Behaviour:
- Reset (arst=1, asynchronous): state=IDLE; flash_req=0; flash_addr=0; instr=0; instr_pc=0; instr_boot=0; instr_valid=0; fetch_err=0; timeout counter=0; discard flag=0.
- flash_ready = (state==IDLE). It is combinational from the state register, so it is 1 during reset.
- States:
  - IDLE: when pc_valid=1, register pc_in into instr_pc and bootstrapping into instr_boot. Next state RD_LO, with flash_req=1 and flash_addr={pc_in,1'b0} registered. pc_valid is ignored in every other state.
  - RD_LO: flash_req and flash_addr are held stable until ack. On flash_ack, latch instr[7:0]=flash_rdata, set flash_addr={pc,1'b1}, and go to RD_HI with flash_req kept at 1.
  - RD_HI: on flash_ack, latch instr[15:8], drop flash_req, go to HOLD, and set instr_valid=1.
  - HOLD: outputs are stable. If instr_valid & instr_ready, clear instr_valid and fetch_err, and go to IDLE next cycle.
- Minimum latency, with ack in the same cycle as req: pc_valid at cycle T -> flash_req at T+1 -> high read at T+2 -> instr_valid at T+3. flash_ready rises the cycle after handoff.
- Timeout:
  - The counter clears on every entry to RD_LO or RD_HI and increments each cycle without ack.
  - When count reaches TIMEOUT_CYCLES-1 without ack: drop flash_req, set instr=NOP_WORD, fetch_err=1, instr_valid=1, and go to HOLD.
  - An ack arriving in the same cycle as the final count takes priority; the read completes normally.
- Flush:
  - In IDLE: no effect.
  - In RD_LO/RD_HI: set the discard flag. The current byte read still completes, since flash_req never drops without ack or timeout. On that ack or timeout, go to IDLE with instr_valid=0. No second byte is requested after a discarded low read.
  - In HOLD: clear instr_valid and fetch_err and go to IDLE next cycle. Flush wins over instr_ready in the same cycle.
- Simultaneous pc_valid and flush in IDLE: pc_valid is captured; flush is ignored.
- An ack while flash_req=0 is ignored.
- flash_addr does not change while flash_req=1 except on the ack cycle of RD_LO.
- Address arithmetic: {pc,1} cannot overflow, so no wrap handling is needed. PC 0xFFF fetches bytes 0x1FFE/0x1FFF.
- Reset mid-transaction aborts immediately: flash_req=0 and state=IDLE.

Test Plan:
- Zero-wait fetch: reset release, pc_in=0x000, pc_valid=1, bootstrapping=1; flash acks same cycle with 0x34 then 0x12 -> addrs 0x0000, 0x0001; instr=0x1234, instr_pc=0x000, instr_boot=1, instr_valid at T+3; flash_ready=0 from T+1 until the cycle after handoff.
- Wait states plus backpressure: pc_in=0x200, ack after 3 cycles per byte (0xCD, 0xAB), instr_ready low for 4 cycles -> instr=0xABCD held stable, instr_boot=0, instr_valid drops one cycle after instr_ready=1.
- Timeout: no ack on the low read -> flash_req drops after TIMEOUT_CYCLES=16 cycles; instr=0x0000, fetch_err=1; a late ack is ignored.
- Flush during RD_HI: ack low 0x11, assert flush, ack high 0x22 -> instr_valid never asserts; state IDLE; next pc_valid with 0x050 fetches addrs 0x00A0/0x00A1.
- Flush in HOLD with instr_ready=1 in the same cycle -> instruction dropped, no handoff counted.
- Reset mid-RD_LO: assert arst -> flash_req=0 and flash_ready=1 immediately, asynchronously; all outputs at reset values.

Source files
------------

// File: rtl/instr_fetch.sv
// Fetch stage: reads a 16-bit instruction as two byte reads from program flash
// and presents it to the decoder under a valid/ready handshake.
module instr_fetch #(
  parameter int          ADDR_WIDTH     = 12,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [15:0] NOP_WORD       = 16'h0000
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  pc_valid,
  input  logic                  bootstrapping,
  output logic                  flash_ready,
  input  logic                  flush,
  output logic                  flash_req,
  output logic [ADDR_WIDTH:0]   flash_addr,
  input  logic [7:0]            flash_rdata,
  input  logic                  flash_ack,
  output logic [15:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_boot,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state_r, state_s;
  logic [7:0]            cnt_r, cnt_s;
  logic                  discard_r, discard_s;
  logic                  req_s;
  logic [ADDR_WIDTH:0]   addr_s;
  logic [15:0]           instr_s;
  logic [ADDR_WIDTH-1:0] pc_s;
  logic                  boot_s;
  logic                  valid_s;
  logic                  err_s;
  logic                  drop_s;
  logic                  expired_s;

  assign flash_ready = (state_r == IDLE);

  // Next-state and next-output logic for the fetch sequencer.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    discard_s = discard_r;
    req_s     = flash_req;
    addr_s    = flash_addr;
    instr_s   = instr;
    pc_s      = instr_pc;
    boot_s    = instr_boot;
    valid_s   = instr_valid;
    err_s     = fetch_err;
    // A flush landing on the completing cycle still discards the fetch.
    drop_s    = discard_r | flush;
    expired_s = (cnt_r == CNT_LAST);
    case (state_r)
      IDLE: begin
        if (pc_valid) begin
          pc_s      = pc_in;
          boot_s    = bootstrapping;
          req_s     = 1'b1;
          addr_s    = {pc_in, 1'b0};
          cnt_s     = 8'd0;
          discard_s = 1'b0;
          state_s   = RD_LO;
        end else begin
          state_s = IDLE;
        end
      end
      RD_LO: begin
        if (flash_ack) begin
          instr_s[7:0] = flash_rdata;
          if (drop_s) begin
            req_s     = 1'b0;
            discard_s = 1'b0;
            state_s   = IDLE;
          end else begin
            addr_s  = {instr_pc, 1'b1};
            cnt_s   = 8'd0;
            state_s = RD_HI;
          end
        end else if (expired_s) begin
          req_s     = 1'b0;
          discard_s = 1'b0;
          if (drop_s) begin
            state_s = IDLE;
          end else begin
            instr_s = NOP_WORD;
            err_s   = 1'b1;
            valid_s = 1'b1;
            state_s = HOLD;
          end
        end else begin
          cnt_s     = cnt_r + 8'd1;
          discard_s = drop_s;
        end
      end
      RD_HI: begin
        if (flash_ack) begin
          instr_s[15:8] = flash_rdata;
          req_s         = 1'b0;
          discard_s     = 1'b0;
          if (drop_s) begin
            state_s = IDLE;
          end else begin
            valid_s = 1'b1;
            state_s = HOLD;
          end
        end else if (expired_s) begin
          req_s     = 1'b0;
          discard_s = 1'b0;
          if (drop_s) begin
            state_s = IDLE;
          end else begin
            instr_s = NOP_WORD;
            err_s   = 1'b1;
            valid_s = 1'b1;
            state_s = HOLD;
          end
        end else begin
          cnt_s     = cnt_r + 8'd1;
          discard_s = drop_s;
        end
      end
      HOLD: begin
        if (flush || (instr_valid && instr_ready)) begin
          valid_s = 1'b0;
          err_s   = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s   = IDLE;
        req_s     = 1'b0;
        valid_s   = 1'b0;
        err_s     = 1'b0;
        discard_s = 1'b0;
        cnt_s     = 8'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      discard_r   <= 1'b0;
      flash_req   <= 1'b0;
      flash_addr  <= '0;
      instr       <= 16'h0000;
      instr_pc    <= '0;
      instr_boot  <= 1'b0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      discard_r   <= discard_s;
      flash_req   <= req_s;
      flash_addr  <= addr_s;
      instr       <= instr_s;
      instr_pc    <= pc_s;
      instr_boot  <= boot_s;
      instr_valid <= valid_s;
      fetch_err   <= err_s;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a byte-array flash model answers reads and
// each fetch's outcome is predicted from the chosen ack delays and flush points.
module tb_instr_fetch;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        arst;
  logic [11:0] pc_in;
  logic        pc_valid;
  logic        bootstrapping;
  logic        flash_ready;
  logic        flush;
  logic        flash_req;
  logic [12:0] flash_addr;
  logic [7:0]  flash_rdata;
  logic        flash_ack;
  logic [15:0] instr;
  logic [11:0] instr_pc;
  logic        instr_boot;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_err;

  logic [7:0]  mem [0:8191];
  int          n_vec = 0;
  int          n_err = 0;

  instr_fetch #(
    .ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(TMO),
    .NOP_WORD(16'h0000)
  ) dut (
    .clk(clk), .arst(arst), .pc_in(pc_in), .pc_valid(pc_valid),
    .bootstrapping(bootstrapping), .flash_ready(flash_ready), .flush(flush),
    .flash_req(flash_req), .flash_addr(flash_addr), .flash_rdata(flash_rdata),
    .flash_ack(flash_ack), .instr(instr), .instr_pc(instr_pc),
    .instr_boot(instr_boot), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One byte read: ack d cycles after the request is seen, flush at cycle fl.
  task automatic rd_phase(input logic [12:0] addr, input int d, input int fl,
                          output logic disc, output logic tmo);
    disc = 1'b0;
    tmo  = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      chk("req_high", 32'(flash_req), 32'd1);
      chk("addr", 32'(flash_addr), 32'(addr));
      chk("busy", 32'(flash_ready), 32'd0);
      chk("no_valid", 32'(instr_valid), 32'd0);
      flush = (k == fl);
      if (k == fl) disc = 1'b1;
      if (k == d) begin
        flash_ack   = 1'b1;
        flash_rdata = mem[int'(addr)];
      end
      step();
      flush     = 1'b0;
      flash_ack = 1'b0;
      if (k == d) return;
    end
    tmo = 1'b1;
  endtask

  task automatic fetch(input logic [11:0] pc, input logic boot, input int d_lo,
                       input int d_hi, input int fl_lo, input int fl_hi,
                       input int rdy, input logic fl_hold, input logic late_ack);
    logic        disc;
    logic        tmo;
    logic [15:0] exp_i;
    logic        exp_err;
    chk("idle_ready", 32'(flash_ready), 32'd1);
    chk("idle_valid", 32'(instr_valid), 32'd0);
    pc_in         = pc;
    pc_valid      = 1'b1;
    bootstrapping = boot;
    flush         = 1'($urandom_range(0, 1));
    flash_ack     = late_ack;
    flash_rdata   = 8'hEE;
    step();
    pc_valid      = 1'b0;
    flush         = 1'b0;
    flash_ack     = 1'b0;
    bootstrapping = 1'($urandom_range(0, 1));
    pc_in         = 12'($urandom);
    exp_err       = 1'b0;
    rd_phase({pc, 1'b0}, d_lo, fl_lo, disc, tmo);
    if (!disc && tmo) begin
      exp_i   = 16'h0000;
      exp_err = 1'b1;
    end else if (!disc) begin
      rd_phase({pc, 1'b1}, d_hi, fl_hi, disc, tmo);
      exp_i   = tmo ? 16'h0000 : {mem[{pc, 1'b1}], mem[{pc, 1'b0}]};
      exp_err = tmo;
    end else begin
      exp_i = 16'h0000;
    end
    if (disc) begin
      chk("disc_idle", 32'(flash_ready), 32'd1);
      chk("disc_req", 32'(flash_req), 32'd0);
      chk("disc_valid", 32'(instr_valid), 32'd0);
      return;
    end
    for (int r = 0; r <= rdy; r++) begin
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_instr", 32'(instr), 32'(exp_i));
      chk("hold_pc", 32'(instr_pc), 32'(pc));
      chk("hold_boot", 32'(instr_boot), 32'(boot));
      chk("hold_err", 32'(fetch_err), 32'(exp_err));
      chk("hold_req", 32'(flash_req), 32'd0);
      chk("hold_busy", 32'(flash_ready), 32'd0);
      if (r < rdy) begin
        instr_ready = 1'b0;
        flush       = 1'b0;
        flash_ack   = late_ack && (r == 0);
        flash_rdata = ~exp_i[7:0];
      end else begin
        instr_ready = 1'b1;
        flush       = fl_hold;
      end
      step();
      flash_ack = 1'b0;
    end
    instr_ready = 1'b0;
    flush       = 1'b0;
    chk("handoff_valid", 32'(instr_valid), 32'd0);
    chk("handoff_err", 32'(fetch_err), 32'd0);
    chk("handoff_ready", 32'(flash_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d_lo;
    int d_hi;
    int fl_lo;
    int fl_hi;
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mem[0]     = 8'h34; mem[1]     = 8'h12;
    mem[13'h400] = 8'hCD; mem[13'h401] = 8'hAB;
    mem[13'h246] = 8'h11; mem[13'h247] = 8'h22;
    arst = 1'b1; pc_in = 12'h000; pc_valid = 1'b0; bootstrapping = 1'b0;
    flush = 1'b0; flash_rdata = 8'h00; flash_ack = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(flash_ready), 32'd1);
    chk("rst_req", 32'(flash_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    step();
    arst = 1'b0;
    step();

    fetch(12'h000, 1'b1, 0, 0, -1, -1, 0, 1'b0, 1'b0);     // zero-wait
    fetch(12'h200, 1'b0, 3, 3, -1, -1, 4, 1'b0, 1'b0);     // waits + backpressure
    fetch(12'h321, 1'b0, 20, 0, -1, -1, 3, 1'b0, 1'b1);    // timeout, late ack
    fetch(12'h322, 1'b1, 15, 15, -1, -1, 1, 1'b0, 1'b0);   // ack on final count
    fetch(12'h123, 1'b0, 0, 2, -1, 1, 0, 1'b0, 1'b0);      // flush in RD_HI
    fetch(12'h050, 1'b0, 0, 0, -1, -1, 0, 1'b0, 1'b0);
    fetch(12'h0A5, 1'b0, 1, 1, -1, -1, 2, 1'b1, 1'b0);     // flush in HOLD
    fetch(12'hFFF, 1'b0, 0, 1, -1, -1, 0, 1'b0, 1'b0);     // top of PC range

    for (int t = 0; t < 150; t++) begin
      d_lo  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
      d_hi  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
      fl_lo = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1;
      fl_hi = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1;
      fetch(12'($urandom), 1'($urandom_range(0, 1)), d_lo, d_hi, fl_lo, fl_hi,
            int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a low-byte read.
    pc_in = 12'h3A5; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    step();
    chk("pre_rst_req", 32'(flash_req), 32'd1);
    #2 arst = 1'b1;
    #1;
    chk("arst_req", 32'(flash_req), 32'd0);
    chk("arst_ready", 32'(flash_ready), 32'd1);
    chk("arst_addr", 32'(flash_addr), 32'd0);
    chk("arst_pc", 32'(instr_pc), 32'd0);
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    arst = 1'b0;
    step();
    fetch(12'h3A5, 1'b1, 2, 0, -1, -1, 1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
